// File: rtl/dmem_if.sv
// dmem_if: MEM-stage request/response bundle for the data-memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data RAM responder with store byte-lane steering and load extension.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                state, state_nx;
    logic [3:0]            cnt;
    logic                  we_q, uns_q, err_q, rsp_err_q;
    logic [1:0]            size_q, off_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q, rdata_q;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  accept, access, req_err;
    logic [31:0]           word, load_val, wr_data;
    logic [3:0]            wr_lanes;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;

    assign accept  = state == IDLE && bus.req_valid;
    assign access  = state == WAIT && cnt == 4'd0;
    assign req_err = bus.req_size == 2'b11
                  || (bus.req_size == 2'b01 && bus.req_addr[0])
                  || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                  || bus.req_addr[31:ADDR_WIDTH+2] != '0;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.req_valid ? WAIT : IDLE;
            WAIT:    state_nx = cnt == 4'd0 ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Errored requests pass through WAIT with a zero count so they answer one edge after accept.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt     <= req_err ? 4'd0 : 4'(LATENCY);
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            err_q   <= req_err;
            size_q  <= bus.req_size;
            off_q   <= bus.req_addr[1:0];
            idx_q   <= bus.req_addr[ADDR_WIDTH+1:2];
            wdata_q <= bus.req_wdata;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end

    assign word     = mem[idx_q];
    assign lane_b   = word[{off_q, 3'b000} +: 8];
    assign lane_h   = word[{off_q[1], 4'b0000} +: 16];
    assign load_val = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b}
                    : size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h}
                    : word;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end else if (access) begin
            rdata_q   <= (err_q || we_q) ? 32'd0 : load_val;
            rsp_err_q <= err_q;
        end

    // Store data is replicated across lanes so the lane mask alone picks the destination.
    assign wr_lanes = size_q == 2'b10 ? 4'b1111
                    : size_q == 2'b01 ? (off_q[1] ? 4'b1100 : 4'b0011)
                    : 4'b0001 << off_q;
    assign wr_data  = size_q == 2'b10 ? wdata_q
                    : size_q == 2'b01 ? {2{wdata_q[15:0]}}
                    : {4{wdata_q[7:0]}};

    always_ff @(posedge clk)
        if (access && we_q && !err_q)
            for (int i = 0; i < 4; i++)
                if (wr_lanes[i]) mem[idx_q][8*i +: 8] <= wr_data[8*i +: 8];

    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
